// File: rtl/bsram_pkg.sv
// Shared definitions for the simple dual-port single-clock block RAM:
// read/write mode encodings, block-select width and the byte-lane count.
package bsram_pkg;

    // READ_MODE encodings
    localparam logic READ_BYPASS   = 1'b0;
    localparam logic READ_PIPELINE = 1'b1;

    // WRITE_MODE encodings (behaviour on a same-address read/write collision)
    localparam logic WRITE_READ_FIRST = 1'b0;
    localparam logic WRITE_THROUGH    = 1'b1;

    // Width of the BLKSELA / BLKSELB block-select fields
    localparam int BLK_SEL_W = 3;

    // Number of byte lanes covering a word; the top lane may be partial
    function automatic int lane_count(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/bsram_sdp_sc_if.sv
// Bus bundle for bsram_sdp_sc: write port A, read port B and the read result.
// BEA is present only when BSRAM_SDP_BYTE_WRITE_EN is defined.
interface bsram_sdp_sc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);

    localparam int LANES = bsram_pkg::lane_count(DATA_WIDTH);

    logic                           CEA;
    logic [ADDR_WIDTH-1:0]          ADA;
    logic [DATA_WIDTH-1:0]          DIA;
    logic [bsram_pkg::BLK_SEL_W-1:0] BLKSELA;
`ifdef BSRAM_SDP_BYTE_WRITE_EN
    logic [LANES-1:0]               BEA;
`endif
    logic                           CEB;
    logic [ADDR_WIDTH-1:0]          ADB;
    logic [bsram_pkg::BLK_SEL_W-1:0] BLKSELB;
    logic                           OCE;
    logic [DATA_WIDTH-1:0]          DO;
    logic                           DO_VALID;

    modport master (
        output CEA, ADA, DIA, BLKSELA,
`ifdef BSRAM_SDP_BYTE_WRITE_EN
        output BEA,
`endif
        output CEB, ADB, BLKSELB, OCE,
        input  DO, DO_VALID
    );

    modport slave (
        input  CEA, ADA, DIA, BLKSELA,
`ifdef BSRAM_SDP_BYTE_WRITE_EN
        input  BEA,
`endif
        input  CEB, ADB, BLKSELB, OCE,
        output DO, DO_VALID
    );

endinterface

// File: rtl/bsram_out_stage.sv
// Read-side pipeline: read-stage register (p0) and optional output
// register (p1) gated by oce, each with its valid bit alongside.
module bsram_out_stage
    import bsram_pkg::*;
#(
    parameter int   DATA_WIDTH = 16,
    parameter logic READ_MODE  = READ_BYPASS
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  oce,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld
);

    logic [DATA_WIDTH-1:0] data_p0;
    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;

    // Stage p0: capture the word on an accepted read, otherwise hold data and drop valid
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= rd_en;
            if (rd_en) begin
                data_p0 <= rd_data;
            end
        end
    end

    // Stage p1: output register advances only while oce is high
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (oce) begin
            data_p1 <= data_p0;
            vld_p1  <= vld_p0;
        end
    end

    assign dout     = (READ_MODE == READ_PIPELINE) ? data_p1 : data_p0;
    assign dout_vld = (READ_MODE == READ_PIPELINE) ? vld_p1  : vld_p0;

endmodule

// File: rtl/bsram_sdp_sc.sv
// Simple dual-port, single-clock block RAM: port A writes, port B reads.
// Optional byte-lane write masking is enabled with BSRAM_SDP_BYTE_WRITE_EN.
module bsram_sdp_sc
    import bsram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic                  READ_MODE  = READ_BYPASS,
    parameter logic                  WRITE_MODE = WRITE_READ_FIRST,
    parameter logic [BLK_SEL_W-1:0]  BLK_SEL_0  = 3'b000,
    parameter logic [BLK_SEL_W-1:0]  BLK_SEL_1  = 3'b000
) (
    input  logic         CLK,
    input  logic         RESETN,
    bsram_sdp_sc_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = lane_count(DATA_WIDTH);

    // Contents start at zero in two-state simulation; reset never clears them
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_en;
    logic                  rd_en;
    logic                  collide;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;

`ifdef BSRAM_SDP_BYTE_WRITE_EN
    // Bitwise merge: each bit follows the enable of the lane it sits in
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (be[i / 8]) begin
                res[i] = new_word[i];
            end
        end
        return res;
    endfunction

    assign wr_word = merge_lanes(mem[bus.ADA], bus.DIA, bus.BEA);
`else
    assign wr_word = bus.DIA;
`endif

    assign wr_en   = bus.CEA && (bus.BLKSELA == BLK_SEL_0);
    assign rd_en   = bus.CEB && (bus.BLKSELB == BLK_SEL_1);
    assign collide = wr_en && (bus.ADA == bus.ADB);

    // Write-through forwards the merged write word; read-first sees the old contents
    assign rd_word = ((WRITE_MODE == WRITE_THROUGH) && collide) ? wr_word : mem[bus.ADB];

    // Memory array write; independent of reset so reset-cycle writes complete
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[bus.ADA] <= wr_word;
        end
    end

    bsram_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .READ_MODE  (READ_MODE)
    ) u_out_stage (
        .clk      (CLK),
        .resetn   (RESETN),
        .rd_en    (rd_en),
        .rd_data  (rd_word),
        .oce      (bus.OCE),
        .dout     (bus.DO),
        .dout_vld (bus.DO_VALID)
    );

    // LANES only feeds the byte-write merge
    if (LANES < 1) begin : g_lane_guard
        $error("DATA_WIDTH must be at least 1");
    end

endmodule

// File: tb/tb_bsram_sdp_sc.sv
// Testbench for bsram_sdp_sc: three instances (bypass/read-first,
// pipeline/read-first, bypass/write-through) share one stimulus stream.
module tb_bsram_sdp_sc;

    logic        clk = 1'b0;
    logic        resetn, cea, ceb, oce;
    logic [9:0]  ada, adb;
    logic [15:0] dia;
    logic [2:0]  bsa, bsb;
`ifdef BSRAM_SDP_BYTE_WRITE_EN
    logic [1:0]  bea;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: memory image and the expected output of each instance
    logic [15:0] m_mem [1024];
    logic [15:0] a_do, b_do, c_do;
    logic        a_v, b_v, c_v;

    always #5 clk = ~clk;

    bsram_sdp_sc_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus_a ();
    bsram_sdp_sc_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus_b ();
    bsram_sdp_sc_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus_c ();

`define TB_DRIVE(b) \
    assign b.CEA = cea; assign b.ADA = ada; assign b.DIA = dia; assign b.BLKSELA = bsa; \
    assign b.CEB = ceb; assign b.ADB = adb; assign b.BLKSELB = bsb; assign b.OCE = oce;
    `TB_DRIVE(bus_a)
    `TB_DRIVE(bus_b)
    `TB_DRIVE(bus_c)
`undef TB_DRIVE
`ifdef BSRAM_SDP_BYTE_WRITE_EN
    assign bus_a.BEA = bea;
    assign bus_b.BEA = bea;
    assign bus_c.BEA = bea;
`endif

    bsram_sdp_sc #(.READ_MODE(1'b0), .WRITE_MODE(1'b0)) dut_a (.CLK(clk), .RESETN(resetn), .bus(bus_a));
    bsram_sdp_sc #(.READ_MODE(1'b1), .WRITE_MODE(1'b0)) dut_b (.CLK(clk), .RESETN(resetn), .bus(bus_b));
    bsram_sdp_sc #(.READ_MODE(1'b0), .WRITE_MODE(1'b1)) dut_c (.CLK(clk), .RESETN(resetn), .bus(bus_c));

    typedef struct packed {
        logic        rstn;
        logic        cea;
        logic [9:0]  ada;
        logic [15:0] dia;
        logic [2:0]  bsa;
        logic        ceb;
        logic [9:0]  adb;
        logic [2:0]  bsb;
        logic [15:0] exp_a;
        logic [15:0] exp_c;
        logic        exp_v;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One clock: the model applies the rules to the inputs present at the edge
    task automatic cycle();
        logic        wr, rd;
        logic [15:0] old, nw, thru;
        wr  = cea && (bsa == 3'b000);
        rd  = ceb && (bsb == 3'b000);
        old = m_mem[adb];
        nw  = dia;
`ifdef BSRAM_SDP_BYTE_WRITE_EN
        for (int i = 0; i < 16; i++) begin
            nw[i] = bea[i / 8] ? dia[i] : m_mem[ada][i];
        end
`endif
        thru = (wr && (ada == adb)) ? nw : old;
        @(posedge clk);
        if (wr) m_mem[ada] = nw;
        if (!resetn) begin
            a_do = '0; b_do = '0; c_do = '0;
            a_v  = 0;  b_v  = 0;  c_v  = 0;
        end else begin
            // pipeline output is the bypass result delayed by one OCE-enabled edge
            if (oce) begin
                b_do = a_do;
                b_v  = a_v;
            end
            a_v = rd;
            c_v = rd;
            if (rd) begin
                a_do = old;
                c_do = thru;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        cea = 0; ceb = 0; ada = '0; adb = '0; dia = '0; bsa = '0; bsb = '0;
    endtask

    task automatic chk_b(input string nm, input logic [15:0] exp_do, input logic exp_v);
        chk({nm, "_do"}, bus_b.DO, exp_do);
        chk({nm, "_vld"}, {15'd0, bus_b.DO_VALID}, {15'd0, exp_v});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = '0;
        a_do = '0; b_do = '0; c_do = '0; a_v = 0; b_v = 0; c_v = 0;
        resetn = 0; oce = 1;
        set_idle();
`ifdef BSRAM_SDP_BYTE_WRITE_EN
        bea = 2'b11;
`endif

        //            rstn cea ada     dia       bsa  ceb adb     bsb  exp_a     exp_c     v
        tbl[0]  = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 1, 10'h000, 3'd0, 16'h0000, 16'h0000, 1'b1};
        tbl[1]  = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 1, 10'h001, 3'd0, 16'h0000, 16'h0000, 1'b1};
        tbl[2]  = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 0, 10'h000, 3'd0, 16'h0000, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 1, 10'h000, 16'hFEED, 3'd0, 0, 10'h000, 3'd0, 16'h0000, 16'h0000, 1'b0};
        tbl[4]  = '{1'b1, 1, 10'h3FF, 16'hBEEF, 3'd0, 0, 10'h000, 3'd0, 16'h0000, 16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 1, 10'h3FF, 3'd0, 16'hBEEF, 16'hBEEF, 1'b1};
        tbl[6]  = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 1, 10'h000, 3'd0, 16'hFEED, 16'hFEED, 1'b1};
        tbl[7]  = '{1'b1, 1, 10'h005, 16'h1111, 3'd0, 0, 10'h000, 3'd0, 16'hFEED, 16'hFEED, 1'b0};
        tbl[8]  = '{1'b1, 1, 10'h005, 16'h2222, 3'd0, 1, 10'h005, 3'd0, 16'h1111, 16'h2222, 1'b1};
        tbl[9]  = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 1, 10'h005, 3'd0, 16'h2222, 16'h2222, 1'b1};
        tbl[10] = '{1'b1, 1, 10'h007, 16'h5555, 3'd0, 0, 10'h000, 3'd0, 16'h2222, 16'h2222, 1'b0};
        tbl[11] = '{1'b1, 1, 10'h007, 16'hAAAA, 3'd1, 0, 10'h000, 3'd0, 16'h2222, 16'h2222, 1'b0};
        tbl[12] = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 1, 10'h007, 3'd0, 16'h5555, 16'h5555, 1'b1};
        tbl[13] = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 1, 10'h000, 3'd1, 16'h5555, 16'h5555, 1'b0};
        tbl[14] = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 1, 10'h3FF, 3'd0, 16'hBEEF, 16'hBEEF, 1'b1};
        tbl[15] = '{1'b0, 1, 10'h009, 16'h9999, 3'd0, 1, 10'h000, 3'd0, 16'h0000, 16'h0000, 1'b0};
        tbl[16] = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 0, 10'h000, 3'd0, 16'h0000, 16'h0000, 1'b0};
        tbl[17] = '{1'b1, 0, 10'h000, 16'h0000, 3'd0, 1, 10'h009, 3'd0, 16'h9999, 16'h9999, 1'b1};

        // reset state
        cycle();
        cycle();
        chk("rst_a_do", bus_a.DO, 16'h0000);
        chk("rst_a_vld", {15'd0, bus_a.DO_VALID}, 16'h0000);
        chk_b("rst_b", 16'h0000, 1'b0);
        chk("rst_c_do", bus_c.DO, 16'h0000);
        chk("rst_c_vld", {15'd0, bus_c.DO_VALID}, 16'h0000);
        resetn = 1;

        // directed vectors on the bypass instances
        for (int i = 0; i < 18; i++) begin
            resetn = tbl[i].rstn; cea = tbl[i].cea; ada = tbl[i].ada; dia = tbl[i].dia;
            bsa = tbl[i].bsa; ceb = tbl[i].ceb; adb = tbl[i].adb; bsb = tbl[i].bsb;
            cycle();
            chk($sformatf("vec%0d_a_do", i), bus_a.DO, tbl[i].exp_a);
            chk($sformatf("vec%0d_a_vld", i), {15'd0, bus_a.DO_VALID}, {15'd0, tbl[i].exp_v});
            chk($sformatf("vec%0d_c_do", i), bus_c.DO, tbl[i].exp_c);
            chk($sformatf("vec%0d_c_vld", i), {15'd0, bus_c.DO_VALID}, {15'd0, tbl[i].exp_v});
        end
        set_idle();
        resetn = 1;

        // pipeline mode: two-cycle latency, OCE hold, then reset mid-pipeline
        ceb = 1; adb = 10'h000; oce = 1; cycle();
        ceb = 0; cycle();
        chk_b("pipe_lat2", 16'hFEED, 1'b1);
        ceb = 1; adb = 10'h3FF; oce = 0; cycle();
        chk_b("pipe_hold0", 16'hFEED, 1'b1);
        ceb = 0; cycle();
        chk("pipe_hold1_do", bus_b.DO, 16'hFEED);
        cycle();
        chk("pipe_hold2_do", bus_b.DO, 16'hFEED);
        oce = 1; cycle();
        chk("pipe_oce_rise_do", bus_b.DO, 16'hBEEF);
        ceb = 1; adb = 10'h000; cycle();
        chk("pipe_pre_rst_do", bus_b.DO, 16'hBEEF);
        ceb = 0; resetn = 0; cycle();
        chk_b("pipe_rst", 16'h0000, 1'b0);
        resetn = 1; cycle();
        chk_b("pipe_lost", 16'h0000, 1'b0);

`ifdef BSRAM_SDP_BYTE_WRITE_EN
        // byte-lane write: only the low lane is replaced
        cea = 1; ada = 10'h010; dia = 16'h1234; bea = 2'b11; cycle();
        dia = 16'hABCD; bea = 2'b01; cycle();
        cea = 0; ceb = 1; adb = 10'h010; bea = 2'b11; cycle();
        chk("byte_lane_do", bus_a.DO, 16'h12CD);
        ceb = 0;
`endif

        // randomized traffic against the model, biased toward collisions
        for (int n = 0; n < 600; n++) begin
            resetn = ($urandom_range(0, 49) != 0);
            cea    = 1'($urandom_range(0, 1));
            ceb    = ($urandom_range(0, 3) != 0);
            ada    = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
            adb    = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
            dia    = 16'($urandom);
            bsa    = ($urandom_range(0, 7) == 0) ? 3'b010 : 3'b000;
            bsb    = ($urandom_range(0, 7) == 0) ? 3'b100 : 3'b000;
            oce    = 1'($urandom_range(0, 1));
`ifdef BSRAM_SDP_BYTE_WRITE_EN
            bea    = 2'($urandom);
`endif
            cycle();
            chk("rand_a_do", bus_a.DO, a_do);
            chk("rand_a_vld", {15'd0, bus_a.DO_VALID}, {15'd0, a_v});
            chk("rand_b_do", bus_b.DO, b_do);
            chk("rand_b_vld", {15'd0, bus_b.DO_VALID}, {15'd0, b_v});
            chk("rand_c_do", bus_c.DO, c_do);
            chk("rand_c_vld", {15'd0, bus_c.DO_VALID}, {15'd0, c_v});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsram_sdp_sc.md
BSRAM_SDP_SC -- requirements
Module: bsram_sdp_sc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning word width in bits (legal 1..36).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning word address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter READ_MODE, default 1'b0, meaning 0 = bypass (1-cycle latency) and 1 = pipeline (2-cycle latency).
REQ-004 SHALL have parameter WRITE_MODE, default 1'b0, meaning 0 = read-before-write and 1 = write-through on a same-address collision.
REQ-005 SHALL have parameters BLK_SEL_0 and BLK_SEL_1, default 3'b000 each, meaning the block IDs matched by BLKSELA and BLKSELB.
REQ-006 CLK  input  1  is the only clock; all state updates on its rising edge.
REQ-007 RESETN  input  1  is the reset: synchronous and active-low.
REQ-008 CEA  input  1  is the write enable for port A.
REQ-009 ADA  input  ADDR_WIDTH  is the write address.
REQ-010 DIA  input  DATA_WIDTH  is the write data.
REQ-011 BLKSELA  input  3  is the write block select.
REQ-012 BEA  input  ceil(DATA_WIDTH/8)  is the byte-lane write mask; the port exists only with the macro (REQ-031).
REQ-013 CEB  input  1  is the read enable for port B.
REQ-014 ADB  input  ADDR_WIDTH  is the read address.
REQ-015 BLKSELB  input  3  is the read block select.
REQ-016 OCE  input  1  is the output-register clock enable (pipeline mode only).
REQ-017 DO  output  DATA_WIDTH  is the read data.
REQ-018 DO_VALID  output  1  is high when DO holds data from an accepted read.

Function
REQ-019 A write is accepted on a rising edge when CEA=1 and BLKSELA==BLK_SEL_0; mem[ADA] <= DIA.
REQ-020 A read is accepted on a rising edge when CEB=1 and BLKSELB==BLK_SEL_1; the read stage latches mem[ADB].
REQ-021 In bypass mode, DO SHALL equal the read-stage register; DO and DO_VALID update 1 cycle after acceptance.
REQ-022 In pipeline mode, the output register SHALL load from the read stage only when OCE=1 and hold otherwise; DO and DO_VALID are valid 2 cycles after acceptance, given OCE=1.
REQ-023 A cycle with no accepted read SHALL hold the read-stage data and clear its valid bit.
REQ-024 On a simultaneous accepted read and write with ADA==ADB, WRITE_MODE=0 SHALL return the old word and WRITE_MODE=1 SHALL return DIA (masked-merged when BEA is present).
REQ-025 A block-select mismatch SHALL make that port a no-op; memory and DO are unchanged.
REQ-026 Addresses SHALL be taken modulo the depth; no out-of-range state exists.
REQ-027 Memory contents after power-up SHALL be all zeros for simulation.

Reset
REQ-028 While RESETN=0 at a rising edge, the read-stage register, the output register, DO and DO_VALID SHALL clear to 0.
REQ-029 Reset SHALL NOT clear memory contents; an accepted write in a reset cycle still completes.
REQ-030 A read accepted in a reset cycle SHALL be discarded; in-flight pipeline data is lost.

Configuration
REQ-031 With macro BSRAM_SDP_BYTE_WRITE_EN defined, BEA SHALL exist and a write SHALL update only the byte lanes whose BEA bit is 1; the top lane covers the remaining DATA_WIDTH%8 bits.
REQ-032 Without BSRAM_SDP_BYTE_WRITE_EN, BEA SHALL be absent and every accepted write SHALL update the full word.

Structure
REQ-033 Package bsram_pkg SHALL hold the READ_MODE/WRITE_MODE encodings, the byte-lane-count function and the block-select width.
REQ-034 One sub-module, bsram_out_stage, SHALL implement the read-stage and output-register pipeline with DO_VALID tracking.

Verification
REQ-035 Defaults, reset, then read addresses 0 and 1 -> DO=0000 and DO_VALID=1 one cycle after each read.
REQ-036 Write 0x00=FEED and 0x3FF=BEEF, then read 0x3FF and 0x00 back-to-back -> DO=BEEF, then FEED on consecutive cycles.
REQ-037 READ_MODE=1 with OCE low for 3 cycles after a read of BEEF -> DO holds its prior value; BEEF appears the cycle after OCE rises.
REQ-038 Collision: mem[5]=1111; write 2222 and read address 5 in the same cycle -> DO=1111 with WRITE_MODE=0 and DO=2222 with WRITE_MODE=1.
REQ-039 BLKSELA=3'b001 with BLK_SEL_0=0 writes 0xAAAA to address 7 -> a read of address 7 returns the old value; reset mid-pipeline -> DO=0 and DO_VALID=0 the next cycle.
REQ-040 With the macro defined, BEA=2'b01 writing 0xABCD over 0x1234 -> the read returns 0x12CD.
